// File: rtl/matvec_sched_ctrl.sv
// Pass scheduler for the matrix-vector processor array: clears, accumulates and drains
// up to NUM_PROC rows per pass, gated by input-valid and output-full flow control.
module matvec_sched_ctrl #(
  parameter int  NUM_PROC = 4,
  parameter int  MAX_N    = 16,
  localparam int NW       = $clog2(MAX_N + 1),
  localparam int PW       = $clog2(NUM_PROC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic          in_valid,
  input  logic          out_full,
  output logic          rst_processor,
  output logic          pop_a_v,
  output logic          push_result,
  output logic [PW-1:0] proc_sel,
  output logic [NW-1:0] row_idx,
  output logic          rst_fifo_in,
  output logic          rst_fifo_out,
  output logic          busy,
  output logic          done,
  output logic          err_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_WIPE, S_ACCUM, S_DRAIN, S_CLEAR, S_FLUSH, S_DONE
  } state_t;

  localparam logic [NW:0]   NP_EXT  = (NW + 1)'(NUM_PROC);
  localparam logic [NW-1:0] NP_W    = NW'(NUM_PROC);
  localparam logic [NW-1:0] MAX_N_W = NW'(MAX_N);

  state_t        state_reg;
  logic [NW-1:0] n_reg;
  logic [NW-1:0] col_reg;
  logic [NW-1:0] row_base_reg;
  logic [PW-1:0] drain_idx_reg;
  logic          err_reg;

  logic [NW:0] remaining;
  logic [NW:0] rows;
  logic [NW:0] base_next;
  logic        n_ok;
  logic        last_col;
  logic        last_row;

  // One extra bit keeps row_base + NUM_PROC from wrapping near MAX_N.
  assign remaining = {1'b0, n_reg} - {1'b0, row_base_reg};
  assign rows      = (remaining < NP_EXT) ? remaining : NP_EXT;
  assign base_next = {1'b0, row_base_reg} + NP_EXT;
  assign last_col  = (col_reg == n_reg - NW'(1));
  assign last_row  = ((NW + 1)'(drain_idx_reg) == rows - (NW + 1)'(1));
  assign n_ok      = (n != '0) && (n <= MAX_N_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      n_reg         <= '0;
      col_reg       <= '0;
      row_base_reg  <= '0;
      drain_idx_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (n_ok) begin
              n_reg     <= n;
              state_reg <= S_WIPE;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_WIPE: begin
          row_base_reg  <= '0;
          col_reg       <= '0;
          drain_idx_reg <= '0;
          state_reg     <= S_ACCUM;
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (last_col) begin
              col_reg   <= '0;
              state_reg <= S_DRAIN;
            end else begin
              col_reg <= col_reg + NW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!out_full) begin
            if (last_row) begin
              drain_idx_reg <= '0;
              state_reg     <= (base_next >= {1'b0, n_reg}) ? S_FLUSH : S_CLEAR;
            end else begin
              drain_idx_reg <= drain_idx_reg + PW'(1);
            end
          end
        end
        S_CLEAR: begin
          row_base_reg <= row_base_reg + NP_W;
          state_reg    <= S_ACCUM;
        end
        S_FLUSH: state_reg <= S_DONE;
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rst_processor = (state_reg == S_IDLE) || (state_reg == S_WIPE) || (state_reg == S_CLEAR);
  assign pop_a_v       = (state_reg == S_ACCUM) && in_valid;
  assign push_result   = (state_reg == S_DRAIN) && !out_full;
  assign proc_sel      = (state_reg == S_DRAIN) ? drain_idx_reg : '0;
  assign row_idx       = (state_reg == S_DRAIN) ? (row_base_reg + NW'(drain_idx_reg)) : '0;
  assign rst_fifo_in   = (state_reg == S_FLUSH);
  assign rst_fifo_out  = (state_reg == S_WIPE);
  assign busy          = (state_reg != S_IDLE);
  assign done          = (state_reg == S_DONE);
  assign err_n         = err_reg;

endmodule

// File: tb/tb_matvec_sched_ctrl.sv
// Randomized bench for matvec_sched_ctrl: a step-list model of each run (wipe, pops,
// pushes, clears, flush, done) is built from n and compared every cycle.
module tb_matvec_sched_ctrl;

  localparam int K_WIPE  = 0;
  localparam int K_POP   = 1;
  localparam int K_PUSH  = 2;
  localparam int K_CLEAR = 3;
  localparam int K_FLUSH = 4;
  localparam int K_DONE  = 5;

  typedef struct {
    int kind;
    int sel;
    int row;
  } step_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] n;
  logic       in_valid;
  logic       out_full;
  logic       rst_processor;
  logic       pop_a_v;
  logic       push_result;
  logic [1:0] proc_sel;
  logic [4:0] row_idx;
  logic       rst_fifo_in;
  logic       rst_fifo_out;
  logic       busy;
  logic       done;
  logic       err_n;

  int tests;
  int failed;
  int dc;

  matvec_sched_ctrl #(.NUM_PROC(4), .MAX_N(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n            (n),
    .in_valid     (in_valid),
    .out_full     (out_full),
    .rst_processor(rst_processor),
    .pop_a_v      (pop_a_v),
    .push_result  (push_result),
    .proc_sel     (proc_sel),
    .row_idx      (row_idx),
    .rst_fifo_in  (rst_fifo_in),
    .rst_fifo_out (rst_fifo_out),
    .busy         (busy),
    .done         (done),
    .err_n        (err_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic rp, input logic pop, input logic push,
                                       input logic [1:0] sel, input logic [4:0] row,
                                       input logic fin, input logic fout, input logic bsy,
                                       input logic dn, input logic er);
    return {17'b0, rp, pop, push, sel, row, fin, fout, bsy, dn, er};
  endfunction

  function automatic logic [31:0] obs();
    return pack(rst_processor, pop_a_v, push_result, proc_sel, row_idx,
                rst_fifo_in, rst_fifo_out, busy, done, err_n);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stall-free cycles from WIPE (cycle 1) to DONE, from the pass arithmetic.
  function automatic int latency(input int nn);
    int passes;
    int total;
    passes = (nn + 3) / 4;
    total  = 1;
    for (int p = 0; p < passes; p++)
      total += nn + ((nn - 4 * p) < 4 ? (nn - 4 * p) : 4);
    return total + (passes - 1) + 2;
  endfunction

  task automatic run_one(input int nn, input int pct, input bit hold, input bit pre,
                         output int done_cyc);
    step_t       q[$];
    step_t       s;
    int          passes;
    int          rows;
    int          cyc;
    int          stalls;
    logic [31:0] exp;
    passes = (nn + 3) / 4;
    q.push_back('{K_WIPE, 0, 0});
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c < nn; c++) q.push_back('{K_POP, 0, 0});
      rows = (nn - 4 * p) < 4 ? (nn - 4 * p) : 4;
      for (int d = 0; d < rows; d++) q.push_back('{K_PUSH, d, 4 * p + d});
      if (p < passes - 1) q.push_back('{K_CLEAR, 0, 0});
    end
    q.push_back('{K_FLUSH, 0, 0});
    q.push_back('{K_DONE, 0, 0});

    if (!pre) begin
      start = 1'b1;
      n     = 5'(nn);
      @(negedge clk);
      check("idle_before_start", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
    end
    if (!hold) begin
      start = 1'b0;
      n     = 5'($urandom_range(0, 31));
    end

    cyc      = 0;
    stalls   = 0;
    done_cyc = 0;
    while (q.size() > 0 && cyc < 3000) begin
      in_valid = ($urandom_range(0, 99) >= pct);
      out_full = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      cyc++;
      s = q[0];
      case (s.kind)
        K_WIPE:  exp = pack(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        K_POP:   exp = pack(0, in_valid, 0, 0, 0, 0, 0, 1, 0, 0);
        K_PUSH:  exp = pack(0, 0, !out_full, 2'(s.sel), 5'(s.row), 0, 0, 1, 0, 0);
        K_CLEAR: exp = pack(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        K_FLUSH: exp = pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        default: exp = pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      endcase
      check($sformatf("n%0d_cyc%0d_step%0d", nn, cyc, s.kind), obs(), exp);
      if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (s.kind == K_POP) begin
        if (in_valid) void'(q.pop_front());
        else stalls++;
      end else if (s.kind == K_PUSH) begin
        if (!out_full) void'(q.pop_front());
        else stalls++;
      end else begin
        void'(q.pop_front());
      end
      tick();
    end
    if (q.size() != 0) check("run_timeout", 32'(q.size()), 32'd0);
    check($sformatf("latency_n%0d", nn), 32'(done_cyc), 32'(latency(nn) + stalls));

    in_valid = ($urandom_range(0, 99) >= pct);
    out_full = ($urandom_range(0, 99) < pct);
    @(negedge clk);
    check("idle_after_done", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    $display("[TB] run n=%0d stall_pct=%0d done_cycle=%0d stalls=%0d", nn, pct, done_cyc, stalls);
  endtask

  task automatic err_case(input logic [4:0] bad);
    start = 1'b1;
    n     = bad;
    @(negedge clk);
    check("err_before", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick();
    @(negedge clk);
    check("err_cleared", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    $display("[TB] rejected start n=%0d", bad);
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    n        = '0;
    in_valid = 1'b0;
    out_full = 1'b0;

    tick();
    @(negedge clk);
    check("reset_state", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();

    run_one(8, 0, 1'b0, 1'b0, dc);
    check("done_cycle_n8", 32'(dc), 32'd28);
    run_one(5, 0, 1'b0, 1'b0, dc);
    check("done_cycle_n5", 32'(dc), 32'd19);
    run_one(1, 0, 1'b0, 1'b0, dc);
    check("done_cycle_n1", 32'(dc), 32'd5);
    run_one(16, 0, 1'b0, 1'b0, dc);

    err_case(5'd0);
    err_case(5'd17);

    run_one(4, 30, 1'b0, 1'b0, dc);
    run_one(4, 30, 1'b0, 1'b0, dc);

    // Abort an N=8 run during the second push of the first drain.
    start    = 1'b1;
    n        = 5'd8;
    in_valid = 1'b1;
    out_full = 1'b0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("abort_in_drain", obs(), pack(0, 0, 1, 2'd1, 5'd1, 0, 0, 1, 0, 0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", obs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    $display("[TB] reset during drain of n=8");
    run_one(3, 0, 1'b0, 1'b0, dc);

    // start held through a whole N=2 run, then re-accepted on the single IDLE cycle.
    run_one(2, 0, 1'b1, 1'b0, dc);
    run_one(2, 0, 1'b0, 1'b1, dc);

    for (int r = 0; r < 16; r++)
      run_one($urandom_range(1, 16), $urandom_range(0, 40), 1'b0, 1'b0, dc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
